// File: rtl/dispenser_pkg.sv
// Purpose : shared types and default constants for the grain dispense timer.
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Contents: state_t (IDLE/DISPENSE/SETTLE encoding), tick_t (10-bit tick
//           count), default durations, settle time and debounce length.
package dispenser_pkg;

  localparam int TICK_W   = 10;
  localparam int TICK_MAX = (1 << TICK_W) - 1;

  typedef logic [TICK_W-1:0] tick_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DISPENSE = 2'b01,
    ST_SETTLE   = 2'b10
  } state_t;

  // Default portion durations in 100 Hz ticks (1, 2, 4 and 8 seconds).
  localparam int DEF_DUR0   = 100;
  localparam int DEF_DUR1   = 200;
  localparam int DEF_DUR2   = 400;
  localparam int DEF_DUR3   = 800;
  localparam int DEF_SETTLE = 50;
  localparam int DEF_DEB    = 3;

  // True when a parameter value is representable as a tick count.
  function automatic bit fits_tick(input int v);
    return (v >= 0) && (v <= TICK_MAX);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose : tick-based debouncer; output follows the input only after the
//           input has disagreed with it for DEB_TICKS consecutive ticks.
// Latency : DEB_TICKS tick_i pulses after the input settles.
// Backpres: none; free-running conditioner.
// Ports   : clk_i/rst_ni (sync active-low), tick_i enable pulse,
//           din_i synchronized level, dout_o conditioned level.
// Only compiled when GRAIN_DISPENSE_DEBOUNCE_EN is defined.
`ifdef GRAIN_DISPENSE_DEBOUNCE_EN
module btn_debounce
  import dispenser_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic din_i,
  output logic dout_o
);

  localparam tick_t LIMIT = tick_t'(DEB_TICKS);

  tick_t cnt_q, cnt_d;
  logic  lvl_q, lvl_d;

  // Any clock on which the input agrees with the output breaks the run of
  // disagreeing ticks, so only a sustained change is accepted.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (din_i == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q + 10'd1 >= LIMIT) begin
        lvl_d = din_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign dout_o = lvl_q;

endmodule
`endif

// File: rtl/grain_dispense_timer.sv
// Purpose : timed grain gate controller: start opens the gate for a selected
//           number of 100 Hz ticks, then holds busy through a drain period.
// Latency : start accepted 3 clk after the raw press (2-flop sync + FSM reg);
//           stop closes the gate 3 clk after the raw press.
// Backpres: none; start requests outside IDLE are dropped, not queued.
// Ports   : clk_50MHz, rst_n (sync active-low), tick_100Hz enable pulse,
//           start_btn/stop_btn raw buttons, amount_sel portion select;
//           gate_open, busy, done (1-clk pulse), aborted, remaining ticks.
// Option  : GRAIN_DISPENSE_DEBOUNCE_EN inserts btn_debounce on both buttons.
module grain_dispense_timer
  import dispenser_pkg::*;
#(
  parameter int DUR0         = DEF_DUR0,
  parameter int DUR1         = DEF_DUR1,
  parameter int DUR2         = DEF_DUR2,
  parameter int DUR3         = DEF_DUR3,
  parameter int SETTLE_TICKS = DEF_SETTLE,
  parameter int DEB_TICKS    = DEF_DEB
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       tick_100Hz,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [1:0] amount_sel,
  output logic       gate_open,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [9:0] remaining
);

  localparam bit PARAMS_OK = fits_tick(DUR0) && fits_tick(DUR1) &&
                             fits_tick(DUR2) && fits_tick(DUR3) &&
                             fits_tick(SETTLE_TICKS) &&
                             fits_tick(DEB_TICKS) && (DEB_TICKS >= 1);

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("grain_dispense_timer: parameter does not fit a 10-bit tick count");
    end
  endgenerate

  localparam tick_t DUR0_T   = tick_t'(DUR0);
  localparam tick_t DUR1_T   = tick_t'(DUR1);
  localparam tick_t DUR2_T   = tick_t'(DUR2);
  localparam tick_t DUR3_T   = tick_t'(DUR3);
  localparam tick_t SETTLE_T = tick_t'(SETTLE_TICKS);

  // ---------------------------------------------------------------- sync
  logic start_s1_q, start_s2_q, stop_s1_q, stop_s2_q;

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
    end else begin
      start_s1_q <= start_btn;
      start_s2_q <= start_s1_q;
      stop_s1_q  <= stop_btn;
      stop_s2_q  <= stop_s1_q;
    end
  end

  // ----------------------------------------------------------- condition
  logic start_lvl, stop_lvl;

`ifdef GRAIN_DISPENSE_DEBOUNCE_EN
  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_start (
    .clk_i  (clk_50MHz),
    .rst_ni (rst_n),
    .tick_i (tick_100Hz),
    .din_i  (start_s2_q),
    .dout_o (start_lvl)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_stop (
    .clk_i  (clk_50MHz),
    .rst_ni (rst_n),
    .tick_i (tick_100Hz),
    .din_i  (stop_s2_q),
    .dout_o (stop_lvl)
  );
`else
  assign start_lvl = start_s2_q;
  assign stop_lvl  = stop_s2_q;
`endif

  // -------------------------------------------------------- start edge
  // The synchronizer clears on reset, so a button held through reset would
  // look like a fresh 0->1 edge once the flops refill. Starts stay disarmed
  // until the button has been seen released after the pipeline has refilled.
  logic       start_prev_q, armed_q;
  logic [1:0] fill_q;
  logic       start_req;

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      fill_q       <= 2'd0;
    end else begin
      start_prev_q <= start_lvl;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
      if ((fill_q == 2'd2) && !start_s2_q && !start_lvl) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign start_req = armed_q && start_lvl && !start_prev_q;

  // ------------------------------------------------------ duration select
  tick_t dur_sel;

  always_comb begin
    dur_sel = DUR0_T;
    case (amount_sel)
      2'd0:    dur_sel = DUR0_T;
      2'd1:    dur_sel = DUR1_T;
      2'd2:    dur_sel = DUR2_T;
      2'd3:    dur_sel = DUR3_T;
      default: dur_sel = DUR0_T;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  state_t state_q;
  logic   gate_q, busy_q, done_q, aborted_q;
  tick_t  rem_q;

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Stop held at the same time as a start edge wins and the edge is lost.
          if (start_req && !stop_lvl) begin
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            if (dur_sel != '0) begin
              state_q <= ST_DISPENSE;
              gate_q  <= 1'b1;
              rem_q   <= dur_sel;
            end else begin
              state_q <= ST_SETTLE;
              rem_q   <= SETTLE_T;
            end
          end
        end
        ST_DISPENSE: begin
          if (stop_lvl) begin
            gate_q    <= 1'b0;
            aborted_q <= 1'b1;
            rem_q     <= SETTLE_T;
            state_q   <= ST_SETTLE;
          end else if (tick_100Hz) begin
            // <= 1 rather than == 1 keeps the count from ever wrapping.
            if (rem_q <= 10'd1) begin
              gate_q  <= 1'b0;
              rem_q   <= SETTLE_T;
              state_q <= ST_SETTLE;
            end else begin
              rem_q <= rem_q - 10'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (tick_100Hz) begin
            if (rem_q <= 10'd1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              rem_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              rem_q <= rem_q - 10'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
          rem_q   <= '0;
        end
      endcase
    end
  end

  assign gate_open = gate_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign remaining = rem_q;

endmodule

// File: doc/grain_dispense_timer.md
GRAIN_DISPENSE_TIMER -- requirements
Module: grain_dispense_timer

Interface
REQ-001 Param DUR0, 100: dispense duration in ticks for amount_sel=0 (1.00 s at 100 Hz).
REQ-002 Param DUR1, 200: dispense duration in ticks for amount_sel=1.
REQ-003 Param DUR2, 400: dispense duration in ticks for amount_sel=2.
REQ-004 Param DUR3, 800: dispense duration in ticks for amount_sel=3.
REQ-005 Param SETTLE_TICKS, 50: post-close drain time in ticks.
REQ-006 Param DEB_TICKS, 3: consecutive stable ticks for debounce acceptance.
REQ-007 clk_50MHz  in  1: the single system clock; all logic on its rising edge.
REQ-008 rst_n  in  1: reset, synchronous and active-low.
REQ-009 tick_100Hz  in  1: one-clk-wide enable pulse from the upstream divider stage, nominally every 10 ms.
REQ-010 start_btn  in  1: raw, asynchronous, active-high start button.
REQ-011 stop_btn  in  1: raw, asynchronous, active-high stop/abort button.
REQ-012 amount_sel  in  2: portion selector; sampled only when a start is accepted.
REQ-013 gate_open  out  1: gate actuator drive; 1 = open.
REQ-014 busy  out  1: high in every state except IDLE.
REQ-015 done  out  1: one-clk pulse when a cycle finishes, normal or aborted.
REQ-016 aborted  out  1: high from a stop-terminated DISPENSE until the next accepted start.
REQ-017 remaining  out  10: ticks left in the current DISPENSE or SETTLE phase; 0 in IDLE.

Function
REQ-018 Both buttons SHALL pass through a 2-flop synchronizer before any other use.
REQ-019 States SHALL be IDLE, DISPENSE, SETTLE; the encoding comes from the package.
REQ-020 Start request = rising edge of the conditioned start level (1 clk pulse).
REQ-021 Stop request = conditioned stop level high (level-sensitive).
REQ-022 IDLE + start request + no stop: latch DURn[amount_sel] into remaining and clear aborted. Next state is DISPENSE with gate_open=1 on the following clk if DURn>0; if DURn=0, go straight to SETTLE with the gate never opened.
REQ-023 IDLE + start and stop in the same cycle: stop wins; remain in IDLE.
REQ-024 DISPENSE: on each tick_100Hz, remaining decrements by 1. On the tick where remaining goes 1->0, gate_open=0, remaining loads SETTLE_TICKS, and the state moves to SETTLE.
REQ-025 DISPENSE + stop: on the next clk, gate_open=0, aborted=1, remaining loads SETTLE_TICKS, and the state moves to SETTLE. Stop has priority over a same-cycle tick.
REQ-026 SETTLE: decrement on each tick. On the tick reaching 0, pulse done for 1 clk and return to IDLE. Stop has no effect in SETTLE.
REQ-027 Start requests outside IDLE SHALL be discarded, not queued.
REQ-028 Counters SHALL saturate at 0 and never wrap. Parameters SHALL fit in 10 bits; out-of-range values are an elaboration error.
REQ-029 gate_open SHALL be a registered output, glitch-free, and high only in DISPENSE.
REQ-030 Gate open time = DURn ticks +0/-1 tick, since tick phase is unaligned with start.

Reset
REQ-031 rst_n=0 at a clk edge: state=IDLE, gate_open=0, busy=0, done=0, aborted=0, remaining=0; synchronizer and debounce registers clear.
REQ-032 A reset mid-DISPENSE SHALL close the gate on that same edge.
REQ-033 A button held through reset release SHALL NOT generate a start; a fresh edge is required.

Configuration
REQ-034 Macro GRAIN_DISPENSE_DEBOUNCE_EN, when defined, SHALL compile in the debouncers. A conditioned level changes only after the synchronized input differs from it for DEB_TICKS consecutive tick_100Hz pulses.
REQ-035 Without the macro, the conditioned level equals the synchronized input, and DEB_TICKS is unused.

Structure
REQ-036 Package dispenser_pkg SHALL hold the state typedef, the 10-bit tick-count typedef and the default duration constants.
REQ-037 One sub-module, btn_debounce (one instance per button), SHALL exist only under GRAIN_DISPENSE_DEBOUNCE_EN.

Verification
REQ-038 amount_sel=1, start pulse of 5 ticks: gate_open high for 199-200 ticks; remaining then 50; done pulse after 50 further ticks; aborted=0.
REQ-039 amount_sel=3, stop asserted at remaining=500: gate closes next clk; aborted=1; SETTLE runs 50 ticks; done pulses once.
REQ-040 Start and stop asserted in the same cycle in IDLE: no state change; busy stays 0.
REQ-041 Second start during DISPENSE: ignored; duration unchanged; only one done.
REQ-042 rst_n low for 1 clk mid-DISPENSE with start held: gate_open=0 on that edge; no restart until start is released and re-pressed.
REQ-043 With the macro, a 2-tick start glitch is rejected while a 3-tick press is accepted. Without the macro, a 1-clk press after sync is accepted.
